// File: rtl/rng_quality_monitor_if.sv
// Purpose : sample stream and window-result bundle between the mid-square
//           generator side (master) and rng_quality_monitor (slave).
// Ports   : start/continuous/sample_in/sample_valid flow master->slave;
//           busy/done/ones_count/zero_flag/stuck_flag/pass flow slave->master.
interface rng_quality_monitor_if #(
    parameter int WIDTH       = 16,
    parameter int WINDOW_LOG2 = 8
);
    logic                     start;
    logic                     continuous;
    logic [WIDTH-1:0]         sample_in;
    logic                     sample_valid;
    logic                     busy;
    logic                     done;
    logic [WINDOW_LOG2+4:0]   ones_count;
    logic                     zero_flag;
    logic                     stuck_flag;
    logic                     pass;

    modport master (
        output start, continuous, sample_in, sample_valid,
        input  busy, done, ones_count, zero_flag, stuck_flag, pass
    );

    modport slave (
        input  start, continuous, sample_in, sample_valid,
        output busy, done, ones_count, zero_flag, stuck_flag, pass
    );
endinterface

// File: rtl/rng_quality_monitor.sv
// Purpose : windowed monobit / zero / stuck quality monitor for a mid-square RNG.
// Latency : done pulses one cycle after the edge that accepts the last window sample.
// Backpr. : none; samples are accepted only in ACCUM with sample_valid, else dropped.
// Ports   : i_clk, i_rst (sync, active high); mon = slave side of
//           rng_quality_monitor_if (control + samples in, verdict out).
module rng_quality_monitor #(
    parameter int WIDTH       = 16,
    parameter int WINDOW_LOG2 = 8,
    parameter int ONES_LO     = 1920,
    parameter int ONES_HI     = 2176,
    parameter int STUCK_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    rng_quality_monitor_if.slave  mon
);
    localparam int CW = WINDOW_LOG2 + 5;
    localparam int RW = $clog2(STUCK_LIMIT + 1);
    localparam logic [CW-1:0] LO_BOUND = CW'(ONES_LO);
    localparam logic [CW-1:0] HI_BOUND = CW'(ONES_HI);
    localparam logic [RW-1:0] REP_LIM  = RW'(STUCK_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_REPORT} state_t;

    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    state_t                 r_state;
    logic [CW-1:0]          r_ones_acc;
    logic [WINDOW_LOG2-1:0] r_sample_cnt;
    logic [RW-1:0]          r_rep_cnt;
    logic [WIDTH-1:0]       r_prev;
    logic                   r_prev_vld;
    logic                   r_zero_acc;
    logic                   r_stuck_acc;

    logic                   r_busy;
    logic                   r_done;
    logic [CW-1:0]          r_ones_count;
    logic                   r_zero_flag;
    logic                   r_stuck_flag;
    logic                   r_pass;

    // Window state as it will be after accepting the current sample. The last
    // sample of a window must be reflected in the report, so the verdict is
    // registered from these rather than from the accumulators.
    logic                   w_accept;
    logic                   w_last;
    logic                   w_same;
    logic [CW-1:0]          w_ones_next;
    logic                   w_zero_next;
    logic [RW-1:0]          w_rep_next;
    logic                   w_stuck_next;
    logic                   w_pass_next;

    assign w_accept     = (r_state == S_ACCUM) && mon.sample_valid;
    assign w_last       = (r_sample_cnt == '1);
    assign w_same       = r_prev_vld && (mon.sample_in == r_prev);
    assign w_ones_next  = r_ones_acc + popcount(mon.sample_in);
    assign w_zero_next  = r_zero_acc | (mon.sample_in == '0);
    // Run length saturates so it cannot wrap back below the limit.
    assign w_rep_next   = !w_same                ? RW'(1)  :
                          (r_rep_cnt == REP_LIM) ? REP_LIM :
                                                   r_rep_cnt + RW'(1);
    assign w_stuck_next = r_stuck_acc | (w_rep_next >= REP_LIM);
    assign w_pass_next  = (w_ones_next >= LO_BOUND) && (w_ones_next <= HI_BOUND) &&
                          !w_zero_next && !w_stuck_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_ones_acc   <= '0;
            r_sample_cnt <= '0;
            r_rep_cnt    <= '0;
            r_prev       <= '0;
            r_prev_vld   <= 1'b0;
            r_zero_acc   <= 1'b0;
            r_stuck_acc  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ones_count <= '0;
            r_zero_flag  <= 1'b0;
            r_stuck_flag <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_REPORT: begin
                    // Accumulators are unused outside ACCUM; holding them clear
                    // here means every window entry starts from a clean slate
                    // and runs never carry across windows.
                    r_ones_acc   <= '0;
                    r_sample_cnt <= '0;
                    r_rep_cnt    <= '0;
                    r_prev       <= '0;
                    r_prev_vld   <= 1'b0;
                    r_zero_acc   <= 1'b0;
                    r_stuck_acc  <= 1'b0;
                    if ((r_state == S_IDLE) ? mon.start : mon.continuous) begin
                        r_state <= S_ACCUM;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_ones_acc   <= w_ones_next;
                        r_zero_acc   <= w_zero_next;
                        r_stuck_acc  <= w_stuck_next;
                        r_rep_cnt    <= w_rep_next;
                        r_prev       <= mon.sample_in;
                        r_prev_vld   <= 1'b1;
                        r_sample_cnt <= r_sample_cnt + WINDOW_LOG2'(1);
                        if (w_last) begin
                            r_state      <= S_REPORT;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_ones_count <= w_ones_next;
                            r_zero_flag  <= w_zero_next;
                            r_stuck_flag <= w_stuck_next;
                            r_pass       <= w_pass_next;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mon.busy       = r_busy;
    assign mon.done       = r_done;
    assign mon.ones_count = r_ones_count;
    assign mon.zero_flag  = r_zero_flag;
    assign mon.stuck_flag = r_stuck_flag;
    assign mon.pass       = r_pass;
endmodule

// File: tb/tb_rng_quality_monitor.sv
// Purpose : self-checking bench for rng_quality_monitor (4-sample windows).
// Latency : expectations queued at stimulus time, popped on each done pulse.
// Backpr. : n/a; every wait is a fixed number of cycles.
module tb_rng_quality_monitor;
    logic clk;
    logic rst;

    rng_quality_monitor_if #(.WIDTH(16), .WINDOW_LOG2(2)) mon_if ();

    rng_quality_monitor #(
        .WIDTH(16), .WINDOW_LOG2(2), .ONES_LO(24), .ONES_HI(40), .STUCK_LIMIT(3)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .mon   (mon_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [6:0] ones;
        logic       zero;
        logic       stuck;
        logic       pass;
    } exp_t;

    typedef struct {
        logic [15:0] s [4];
        exp_t        e;
    } vec_t;

    vec_t  vecs [9];
    exp_t  sb [$];
    int    done_cyc [$];
    int    n_cmp;
    int    n_err;
    int    cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: DUT samples at posedge, outputs observed at negedge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (mon_if.done === 1'b1) begin
            done_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                check("sb_ones",  32'(mon_if.ones_count), 32'(e.ones));
                check("sb_zero",  32'(mon_if.zero_flag),  32'(e.zero));
                check("sb_stuck", 32'(mon_if.stuck_flag), 32'(e.stuck));
                check("sb_pass",  32'(mon_if.pass),       32'(e.pass));
            end
        end
    endtask

    task automatic set_vec(input int k, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d,
                           input logic [6:0] ones, input logic z, input logic st, input logic p);
        vecs[k].s[0] = a; vecs[k].s[1] = b; vecs[k].s[2] = c; vecs[k].s[3] = d;
        vecs[k].e.ones = ones; vecs[k].e.zero = z; vecs[k].e.stuck = st; vecs[k].e.pass = p;
    endtask

    function automatic exp_t mk(input logic [6:0] ones, input logic z, input logic st, input logic p);
        exp_t e;
        e.ones = ones; e.zero = z; e.stuck = st; e.pass = p;
        return e;
    endfunction

    // Single window, continuous=0, start asserted again mid-window (ignored).
    task automatic run_window(input int k);
        sb.push_back(vecs[k].e);
        mon_if.start = 1'b1;
        step();
        mon_if.start = 1'b0;
        check($sformatf("v%0d_busy_accum", k), 32'(mon_if.busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            mon_if.sample_in    = vecs[k].s[i];
            mon_if.sample_valid = 1'b1;
            mon_if.start        = (i == 1);
            step();
        end
        check($sformatf("v%0d_done_latency", k), 32'(mon_if.done), 32'd1);
        mon_if.sample_valid = 1'b0;
        mon_if.start        = 1'b0;
        step();
        check($sformatf("v%0d_done_width", k), 32'(mon_if.done), 32'd0);
        check($sformatf("v%0d_busy_idle", k),  32'(mon_if.busy), 32'd0);
    endtask

    logic [15:0] alt [12];
    logic [15:0] full [9];
    int          idx;

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;

        set_vec(0, 16'hA5A5, 16'h5A5A, 16'hF00F, 16'h0FF0, 7'd32, 1'b0, 1'b0, 1'b1);
        set_vec(1, 16'h0001, 16'h1234, 16'h0000, 16'hFFFF, 7'd22, 1'b1, 1'b0, 1'b0);
        set_vec(2, 16'h1357, 16'h1357, 16'h1357, 16'h2468, 7'd29, 1'b0, 1'b1, 1'b0);
        set_vec(3, 16'h1357, 16'h1357, 16'h2468, 16'h2468, 7'd26, 1'b0, 1'b0, 1'b1);
        set_vec(4, 16'h0F0F, 16'h00FF, 16'hF000, 16'h000F, 7'd24, 1'b0, 1'b0, 1'b1);
        set_vec(5, 16'hFFFF, 16'hFFF0, 16'h0F0F, 16'h000F, 7'd40, 1'b0, 1'b0, 1'b1);
        set_vec(6, 16'hFFFF, 16'hFFF0, 16'h0F0F, 16'h001F, 7'd41, 1'b0, 1'b0, 1'b0);
        set_vec(7, 16'h0F0F, 16'h00FF, 16'hF000, 16'h0007, 7'd23, 1'b0, 1'b0, 1'b0);
        set_vec(8, 16'h2468, 16'h1357, 16'h1357, 16'h1357, 7'd29, 1'b0, 1'b1, 1'b0);

        rst                 = 1'b1;
        mon_if.start        = 1'b0;
        mon_if.continuous   = 1'b0;
        mon_if.sample_in    = 16'h0;
        mon_if.sample_valid = 1'b0;
        step();
        step();
        check("rst_busy",  32'(mon_if.busy),       32'd0);
        check("rst_done",  32'(mon_if.done),       32'd0);
        check("rst_ones",  32'(mon_if.ones_count), 32'd0);
        check("rst_zero",  32'(mon_if.zero_flag),  32'd0);
        check("rst_stuck", 32'(mon_if.stuck_flag), 32'd0);
        check("rst_pass",  32'(mon_if.pass),       32'd0);
        rst = 1'b0;
        step();

        // Samples in IDLE are ignored: nothing should move.
        mon_if.sample_in    = 16'hFFFF;
        mon_if.sample_valid = 1'b1;
        step();
        check("idle_ignore_busy", 32'(mon_if.busy), 32'd0);
        mon_if.sample_valid = 1'b0;

        for (int k = 0; k < 9; k++) begin
            run_window(k);
        end

        // Alternating valid, continuous: 4 samples per window, done every 8 cycles.
        // Invalid slots carry 0000, which must never reach the zero detector.
        alt = '{16'hA5A5, 16'h5A5A, 16'hF00F, 16'h0FF0,
                16'h0F0F, 16'h00FF, 16'hF000, 16'h000F,
                16'h1357, 16'h1357, 16'h1357, 16'h2468};
        sb.push_back(mk(7'd32, 1'b0, 1'b0, 1'b1));
        sb.push_back(mk(7'd24, 1'b0, 1'b0, 1'b1));
        sb.push_back(mk(7'd29, 1'b0, 1'b1, 1'b0));
        done_cyc.delete();
        mon_if.continuous = 1'b1;
        mon_if.start      = 1'b1;
        step();
        mon_if.start = 1'b0;
        idx = 0;
        for (int c = 0; c < 24; c++) begin
            if (c == 16) mon_if.continuous = 1'b0;
            mon_if.sample_valid = (c % 2 == 0);
            if (c % 2 == 0) begin
                mon_if.sample_in = alt[idx];
                idx++;
            end else begin
                mon_if.sample_in = 16'h0000;
            end
            step();
        end
        mon_if.sample_valid = 1'b0;
        step();
        check("alt_done_count", 32'(done_cyc.size()), 32'd3);
        if (done_cyc.size() == 3) begin
            check("alt_gap1", 32'(done_cyc[1] - done_cyc[0]), 32'd8);
            check("alt_gap2", 32'(done_cyc[2] - done_cyc[1]), 32'd8);
        end
        check("alt_busy_end", 32'(mon_if.busy), 32'd0);

        // Full-rate continuous: a valid 0000 during REPORT must be dropped, and a
        // 1357 run ending one window must not continue into the next.
        full = '{16'h0F0F, 16'h00FF, 16'h1357, 16'h1357, 16'h0000,
                 16'h1357, 16'h1357, 16'h2468, 16'h2468};
        sb.push_back(mk(7'd32, 1'b0, 1'b0, 1'b1));
        sb.push_back(mk(7'd26, 1'b0, 1'b0, 1'b1));
        mon_if.continuous = 1'b1;
        mon_if.start      = 1'b1;
        step();
        mon_if.start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            mon_if.sample_in    = full[i];
            mon_if.sample_valid = 1'b1;
            step();
            if (i == 4) begin
                check("full_busy_next_window", 32'(mon_if.busy), 32'd1);
                mon_if.continuous = 1'b0;
            end
        end
        mon_if.sample_valid = 1'b0;
        step();
        check("full_busy_end", 32'(mon_if.busy), 32'd0);

        // Reset mid-window: the partial window (two zeros) produces no done.
        mon_if.start = 1'b1;
        step();
        mon_if.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mon_if.sample_in    = 16'h0000;
            mon_if.sample_valid = 1'b1;
            step();
        end
        rst                 = 1'b1;
        mon_if.sample_valid = 1'b0;
        step();
        check("abort_busy", 32'(mon_if.busy),       32'd0);
        check("abort_ones", 32'(mon_if.ones_count), 32'd0);
        check("abort_pass", 32'(mon_if.pass),       32'd0);
        rst = 1'b0;
        step();
        check("abort_no_done", 32'(mon_if.done), 32'd0);
        set_vec(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 7'd64, 1'b0, 1'b1, 1'b0);
        run_window(0);

        // IDLE hold: results stay put while samples keep arriving.
        for (int i = 0; i < 6; i++) begin
            mon_if.sample_in    = (i % 2 == 0) ? 16'h0000 : 16'h1111;
            mon_if.sample_valid = 1'b1;
            step();
            check($sformatf("hold_busy_%0d", i), 32'(mon_if.busy),       32'd0);
            check($sformatf("hold_ones_%0d", i), 32'(mon_if.ones_count), 32'd64);
            check($sformatf("hold_zero_%0d", i), 32'(mon_if.zero_flag),  32'd0);
        end
        mon_if.sample_valid = 1'b0;
        step();

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rng_quality_monitor.md
Name: rng_quality_monitor

Overview:
- Downstream consumer of the 16-bit mid-square generator output (`rand_out`).
- Accumulates fixed-size windows of samples and runs a monobit (ones-count) test per window.
- Detects the two mid-square failure modes: collapse to zero, and a stuck or short repeat of the same value.
- Reports a per-window pass/fail verdict to the system controller, which reseeds the generator on failure.

Parameters:
- WIDTH, 16, sample width; must match the generator output.
- WINDOW_LOG2, 8, log2 of samples per window (default 256).
- ONES_LO, 1920, minimum acceptable ones count per window (inclusive).
- ONES_HI, 2176, maximum acceptable ones count per window (inclusive).
- STUCK_LIMIT, 4, number of consecutive identical accepted samples that sets stuck_flag.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, single-cycle pulse that begins window collection from IDLE.
- continuous, input, 1, when 1 a new window begins immediately after each report.
- sample_in, input, WIDTH, generator output (`rand_out`).
- sample_valid, input, 1, qualifies sample_in; tie high when sampling every clock.
- busy, output, 1, high in ACCUM.
- done, output, 1, one-cycle pulse when the window results are valid.
- ones_count, output, WINDOW_LOG2+5, total ones in the last completed window.
- zero_flag, output, 1, last window contained a sample equal to 0.
- stuck_flag, output, 1, last window contained STUCK_LIMIT or more consecutive identical samples.
- pass, output, 1, verdict for the last window: ONES_LO<=ones_count<=ONES_HI and !zero_flag and !stuck_flag.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE.
  - All outputs 0.
  - Internal accumulators, sample counter, repeat counter, previous-sample register and valid bit all cleared.
  - rst overrides every other input, including mid-window; the partial window is discarded and done is not asserted.
- FSM states: IDLE, ACCUM, REPORT.
  - IDLE: start=1 -> ACCUM. The window accumulators clear on this transition. Samples are ignored in IDLE.
  - ACCUM: each cycle with sample_valid=1 is one accepted sample.
    - popcount(sample_in) is added to ones_acc. ones_acc width is WINDOW_LOG2+5, which cannot overflow.
    - sample_cnt increments.
    - When the final sample is accepted (sample_cnt = 2^WINDOW_LOG2-1 before the increment), the FSM moves to REPORT on the next edge.
    - Cycles with sample_valid=0 change nothing.
    - start is ignored in ACCUM.
  - REPORT: lasts exactly one cycle.
    - done=1.
    - ones_count, zero_flag, stuck_flag and pass are registered from the window accumulators, and are valid from the cycle done is high.
    - Next state is ACCUM (accumulators cleared) if continuous=1, else IDLE.
    - A sample presented during REPORT is not accepted and is not counted in any window.
- Latency: done goes high on the cycle after the edge that accepts the last sample of the window.
- Result outputs hold their values until the next REPORT or rst. busy=0 in IDLE and REPORT.
- zero detect: any accepted sample equal to 0 sets the window zero bit. The bit is sticky within the window.
- Stuck detect:
  - The previous accepted sample is held with a valid bit; the valid bit clears at each window start.
  - rep_cnt resets to 1 on the first sample of a window and whenever the new sample differs from the previous one.
  - rep_cnt increments, saturating at STUCK_LIMIT, when the new sample equals the previous one.
  - The window stuck bit sets when rep_cnt reaches STUCK_LIMIT. It is sticky within the window.
  - Runs do not span windows.
- Simultaneous events:
  - The last accepted sample itself counts toward ones, zero and stuck detection before REPORT.
  - With continuous=1, the first sample of the next window is accepted on the cycle after REPORT.

Test Plan:
- Directed scenarios use WINDOW_LOG2=2, ONES_LO=24, ONES_HI=40, STUCK_LIMIT=3.
- Reset, then start, then valid samples A5A5,5A5A,F00F,0FF0 -> ones_count=32, pass=1, zero_flag=0, stuck_flag=0. done pulses exactly one cycle, 1 cycle after the 4th sample.
- Samples 0001,1234,0000,FFFF -> zero_flag=1, pass=0. ones_count=1+5+0+16=22.
- Samples 1357,1357,1357,2468 -> stuck_flag=1, pass=0. Repeat with 1357,1357,2468,2468 -> stuck_flag=0.
- sample_valid toggled 1,0,1,0,... with continuous=1 -> exactly 4 accepted samples per window. Back-to-back done pulses are separated by 8 cycles of valid-alternating input, and windows do not share samples.
- rst asserted after 2 of 4 samples, then start with FFFF x4 -> ones_count=64, pass=0. No done is emitted for the aborted window.
- Idle check: continuous=0 -> after done, busy=0 and outputs hold while samples keep arriving, until the next start.
